// File: rtl/alu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : alu_pkg                                                |
// | Purpose : Shared FSM state type, mode constants and 4-bit        |
// |           function-select codes for the sliced sequential ALU.   |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

  // Logic-mode function select codes
  localparam logic [3:0] FS_NOT_A     = 4'b0000;
  localparam logic [3:0] FS_NOR       = 4'b0001;
  localparam logic [3:0] FS_NA_AND_B  = 4'b0010;
  localparam logic [3:0] FS_ZERO      = 4'b0011;
  localparam logic [3:0] FS_NAND      = 4'b0100;
  localparam logic [3:0] FS_NOT_B     = 4'b0101;
  localparam logic [3:0] FS_XOR       = 4'b0110;
  localparam logic [3:0] FS_A_AND_NB  = 4'b0111;
  localparam logic [3:0] FS_NA_OR_B   = 4'b1000;
  localparam logic [3:0] FS_XNOR      = 4'b1001;
  localparam logic [3:0] FS_B         = 4'b1010;
  localparam logic [3:0] FS_AND       = 4'b1011;
  localparam logic [3:0] FS_ONE       = 4'b1100;
  localparam logic [3:0] FS_A_OR_NB   = 4'b1101;
  localparam logic [3:0] FS_OR        = 4'b1110;
  localparam logic [3:0] FS_A         = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/alu_slice4.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : alu_slice4                                             |
// | Purpose : Combinational 4-bit ALU slice (logic / arithmetic).    |
// | Ports   : a, b  - 4-bit operand nibbles                          |
// |           s     - function select, m - mode (1 = logic)          |
// |           ci    - carry in; f - 4-bit result; co - carry out     |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module alu_slice4
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       ci,
  output logic [3:0] f,
  output logic       co
);

  logic [3:0] x;
  logic [3:0] y;
  logic [4:0] sum;

  // Arithmetic operand shaping: X/Y pick which combinations of A and B
  // feed the adder, so one adder covers add, subtract, increment, etc.
  always_comb begin
    x   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    y   = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    sum = {1'b0, x} + {1'b0, y} + {4'b0000, ci};
  end

  always_comb begin
    f  = 4'h0;
    co = 1'b0;
    if (m == MODE_LOGIC) begin
      case (s)
        FS_NOT_A:    f = ~a;
        FS_NOR:      f = ~(a | b);
        FS_NA_AND_B: f = ~a & b;
        FS_ZERO:     f = 4'h0;
        FS_NAND:     f = ~(a & b);
        FS_NOT_B:    f = ~b;
        FS_XOR:      f = a ^ b;
        FS_A_AND_NB: f = a & ~b;
        FS_NA_OR_B:  f = ~a | b;
        FS_XNOR:     f = ~(a ^ b);
        FS_B:        f = b;
        FS_AND:      f = a & b;
        FS_ONE:      f = 4'hF;
        FS_A_OR_NB:  f = a | ~b;
        FS_OR:       f = a | b;
        default:     f = a;
      endcase
    end else begin
      f  = sum[3:0];
      co = sum[4];
    end
  end

endmodule
`default_nettype wire

// File: rtl/sliced_alu_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : sliced_alu_seq                                         |
// | Purpose : Sequential ALU that processes a WIDTH-bit operation    |
// |           one 4-bit slice per cycle through a single shared      |
// |           alu_slice4, LSB slice first.                           |
// | Ports   : clk, rst_n (async, active-low)                         |
// |           in_valid/in_ready  - operation handshake               |
// |           a, b, s, m, ci     - operands, select, mode, carry-in  |
// |           out_valid/out_ready- result handshake                  |
// |           f, co, zero        - result, MS carry out, f == 0      |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module sliced_alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16  // multiple of 4, at least 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             co,
  output logic             zero
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, f_q;
  logic [3:0]       s_q;
  logic             m_q;
  logic             carry_q;
  logic             co_q;
  logic [IDXW-1:0]  idx_q;

  logic             accept;
  logic             release_res;
  logic             last_slice;
  logic [IDXW+1:0]  bit_ofs;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [3:0]       sl_f;
  logic             sl_co;

  assign accept      = in_valid  && (state == ST_IDLE);
  assign release_res = out_ready && (state == ST_DONE);
  assign last_slice  = (idx_q == IDXW'(NSLICE - 1));

  // Select the current nibble by shifting rather than a variable part-select
  assign bit_ofs = {idx_q, 2'b00};
  assign a_sh    = a_q >> bit_ofs;
  assign b_sh    = b_q >> bit_ofs;

  alu_slice4 u_slice (
    .a  (a_sh[3:0]),
    .b  (b_sh[3:0]),
    .s  (s_q),
    .m  (m_q),
    .ci (carry_q),
    .f  (sl_f),
    .co (sl_co)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)      state_nxt = ST_RUN;
      ST_RUN:  if (last_slice)  state_nxt = ST_DONE;
      ST_DONE: if (release_res) state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, slice walk, result assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= 4'h0;
      m_q     <= MODE_ARITH;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      f_q     <= '0;
      idx_q   <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      s_q     <= s;
      m_q     <= m;
      carry_q <= (m == MODE_LOGIC) ? 1'b0 : ci;
      co_q    <= 1'b0;
      f_q     <= '0;
      idx_q   <= '0;
    end else if (state == ST_RUN) begin
      // Slice carry is 0 in logic mode, so the carry register stays clear
      carry_q <= sl_co;
      f_q     <= (f_q & ~({{(WIDTH-4){1'b0}}, 4'hF} << bit_ofs))
               | ({{(WIDTH-4){1'b0}}, sl_f} << bit_ofs);
      if (last_slice) begin
        co_q  <= sl_co;
        idx_q <= '0;
      end else begin
        idx_q <= idx_q + IDXW'(1);
      end
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign f         = f_q;
  assign co        = co_q;
  assign zero      = (f_q == '0);

endmodule
`default_nettype wire
